// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK burst path: scheduler states, default burst
// geometry and a counter-width helper.
package bpsk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    GUARD
  } sched_state_t;

  localparam int DEF_CYC_PER_SYM  = 64;
  localparam int DEF_PREAMBLE_LEN = 8;
  localparam int DEF_FRAME_LEN    = 32;
  localparam int DEF_GUARD_LEN    = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bpsk_symbol_scheduler_timer.sv
// Cycle-within-symbol counter. The flags describe the cycle that follows the
// coming clock edge, so the scheduler can register its outputs one step ahead.
module symbol_timer
  import bpsk_pkg::*;
#(
  parameter int CYC_PER_SYM = DEF_CYC_PER_SYM
) (
  input  logic clk_sig,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic sym_first,
  output logic sym_last
);

  localparam int CYC_W = cnt_width(CYC_PER_SYM);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_PER_SYM - 1);

  logic [CYC_W-1:0] cyc_reg;
  logic [CYC_W-1:0] cyc_next;

  always_comb begin
    cyc_next = cyc_reg;
    if (clear) begin
      cyc_next = '0;
    end else if (run) begin
      cyc_next = (cyc_reg == CYC_LAST) ? '0 : cyc_reg + CYC_W'(1);
    end
  end

  always_ff @(posedge clk_sig) begin
    if (rst) begin
      cyc_reg <= '0;
    end else begin
      cyc_reg <= cyc_next;
    end
  end

  assign sym_first = (cyc_next == '0);
  assign sym_last  = (cyc_next == CYC_LAST);

endmodule

// File: rtl/bpsk_symbol_scheduler.sv
// Burst sequencer for the BPSK carrier: preamble, data pulled from the bit
// source, then a carrier-off guard. Every control output is a flop.
module bpsk_symbol_scheduler
  import bpsk_pkg::*;
#(
  parameter int CYC_PER_SYM  = DEF_CYC_PER_SYM,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int GUARD_LEN    = DEF_GUARD_LEN
) (
  input  logic clk_sig,
  input  logic rst,
  input  logic start,
  input  logic bit_data,
  input  logic bit_valid,
  output logic bit_ready,
  output logic carrier_en,
  output logic phase_rst,
  output logic phase_inv,
  output logic sym_strobe,
  output logic busy,
  output logic frame_done,
  output logic underrun
);

  localparam int SYM_W = cnt_width(max3(PREAMBLE_LEN, FRAME_LEN, GUARD_LEN));
  localparam logic [SYM_W-1:0] PRE_LAST   = SYM_W'(PREAMBLE_LEN - 1);
  localparam logic [SYM_W-1:0] DATA_LAST  = SYM_W'(FRAME_LEN - 1);
  localparam logic [SYM_W-1:0] GUARD_LAST = SYM_W'(GUARD_LEN - 1);

  sched_state_t     state_reg;
  logic [SYM_W-1:0] sym_reg;
  logic sym_first, sym_last, start_accept;
  logic bit_ready_reg, carrier_en_reg, phase_rst_reg, phase_inv_reg;
  logic sym_strobe_reg, busy_reg, frame_done_reg, underrun_reg;

  assign start_accept = (state_reg == IDLE) && start;

  symbol_timer #(
    .CYC_PER_SYM(CYC_PER_SYM)
  ) u_timer (
    .clk_sig  (clk_sig),
    .rst      (rst),
    .clear    (start_accept),
    .run      (state_reg != IDLE),
    .sym_first(sym_first),
    .sym_last (sym_last)
  );

  always_ff @(posedge clk_sig) begin
    if (rst) begin
      state_reg      <= IDLE;
      sym_reg        <= '0;
      bit_ready_reg  <= 1'b0;
      carrier_en_reg <= 1'b0;
      phase_rst_reg  <= 1'b0;
      phase_inv_reg  <= 1'b0;
      sym_strobe_reg <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      bit_ready_reg  <= 1'b0;
      phase_rst_reg  <= 1'b0;
      sym_strobe_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      // The bit source had its one chance this cycle; a miss is sticky.
      if (bit_ready_reg && !bit_valid) begin
        underrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= PREAMBLE;
            sym_reg        <= '0;
            underrun_reg   <= 1'b0;
            phase_rst_reg  <= 1'b1;
            carrier_en_reg <= 1'b1;
            busy_reg       <= 1'b1;
            sym_strobe_reg <= 1'b1;
            phase_inv_reg  <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (sym_first) begin
            sym_strobe_reg <= 1'b1;
            if (sym_reg == PRE_LAST) begin
              state_reg     <= DATA;
              sym_reg       <= '0;
              phase_inv_reg <= bit_valid & bit_data;
            end else begin
              sym_reg       <= sym_reg + SYM_W'(1);
              phase_inv_reg <= ~sym_reg[0];
            end
          end else if (sym_last && sym_reg == PRE_LAST) begin
            bit_ready_reg <= 1'b1;
          end
        end
        DATA: begin
          if (sym_first) begin
            if (sym_reg == DATA_LAST) begin
              sym_reg        <= '0;
              phase_inv_reg  <= 1'b0;
              carrier_en_reg <= 1'b0;
              if (GUARD_LEN == 0) begin
                state_reg      <= IDLE;
                busy_reg       <= 1'b0;
                frame_done_reg <= 1'b1;
              end else begin
                state_reg <= GUARD;
              end
            end else begin
              sym_reg        <= sym_reg + SYM_W'(1);
              phase_inv_reg  <= bit_valid & bit_data;
              sym_strobe_reg <= 1'b1;
            end
          end else if (sym_last && sym_reg != DATA_LAST) begin
            bit_ready_reg <= 1'b1;
          end
        end
        GUARD: begin
          if (sym_first) begin
            if (sym_reg == GUARD_LAST) begin
              state_reg      <= IDLE;
              sym_reg        <= '0;
              busy_reg       <= 1'b0;
              frame_done_reg <= 1'b1;
            end else begin
              sym_reg <= sym_reg + SYM_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bit_ready  = bit_ready_reg;
  assign carrier_en = carrier_en_reg;
  assign phase_rst  = phase_rst_reg;
  assign phase_inv  = phase_inv_reg;
  assign sym_strobe = sym_strobe_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_bpsk_symbol_scheduler.sv
// Bench for bpsk_symbol_scheduler: default-geometry instance checked every cycle
// against a burst-offset model, minimal-geometry instance checked from a table.
module tb_bpsk_symbol_scheduler;

  localparam int CPS = 64;
  localparam int PL  = 8;
  localparam int FL  = 32;
  localparam int GL  = 2;
  localparam int NSYM = PL + FL + GL;
  localparam int TOT = NSYM * CPS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, bit_data = 1'b0, bit_valid = 1'b0;
  logic d_bit_ready, d_carrier_en, d_phase_rst, d_phase_inv;
  logic d_sym_strobe, d_busy, d_frame_done, d_underrun;

  logic c_start = 1'b0, c_bit_data = 1'b0, c_bit_valid = 1'b0;
  logic c_bit_ready, c_carrier_en, c_phase_rst, c_phase_inv;
  logic c_sym_strobe, c_busy, c_frame_done, c_underrun;

  bpsk_symbol_scheduler #(
    .CYC_PER_SYM(CPS), .PREAMBLE_LEN(PL), .FRAME_LEN(FL), .GUARD_LEN(GL)
  ) dut (
    .clk_sig(clk), .rst(rst), .start(start), .bit_data(bit_data), .bit_valid(bit_valid),
    .bit_ready(d_bit_ready), .carrier_en(d_carrier_en), .phase_rst(d_phase_rst),
    .phase_inv(d_phase_inv), .sym_strobe(d_sym_strobe), .busy(d_busy),
    .frame_done(d_frame_done), .underrun(d_underrun)
  );

  bpsk_symbol_scheduler #(
    .CYC_PER_SYM(2), .PREAMBLE_LEN(1), .FRAME_LEN(1), .GUARD_LEN(0)
  ) dut_small (
    .clk_sig(clk), .rst(rst), .start(c_start), .bit_data(c_bit_data), .bit_valid(c_bit_valid),
    .bit_ready(c_bit_ready), .carrier_en(c_carrier_en), .phase_rst(c_phase_rst),
    .phase_inv(c_phase_inv), .sym_strobe(c_sym_strobe), .busy(c_busy),
    .frame_done(c_frame_done), .underrun(c_underrun)
  );

  int total = 0;
  int bad = 0;

  // Model: position inside the burst as a plain cycle offset k from the first burst cycle.
  bit m_active = 0, m_done = 0, m_under = 0;
  int m_k = 0, m_nbits = 0;
  bit m_bits [FL];

  int busy_cnt, pr_cnt, fd_cnt;
  logic [NSYM-1:0] got_pat;

  function automatic bit is_ready(input int k);
    int s, c;
    s = k / CPS;
    c = k % CPS;
    return (c == CPS - 1) && (s >= PL - 1) && (s <= PL + FL - 2);
  endfunction

  // Output order: bit_ready, carrier_en, phase_rst, phase_inv, sym_strobe, busy, frame_done, underrun
  function automatic logic [7:0] model_out();
    int s, c;
    bit ce, pi;
    if (!m_active) return {6'b0, m_done, m_under};
    s = m_k / CPS;
    c = m_k % CPS;
    ce = (s < PL + FL);
    if (s < PL) pi = (s % 2) == 1;
    else if (s < PL + FL) pi = m_bits[s - PL];
    else pi = 1'b0;
    return {is_ready(m_k), ce, (m_k == 0), pi, (c == 0) && ce, 1'b1, 1'b0, m_under};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_done = 0; m_under = 0; m_k = 0; m_nbits = 0;
    end else if (m_active) begin
      if (is_ready(m_k)) begin
        m_bits[m_nbits] = bit_valid & bit_data;
        if (!bit_valid) m_under = 1;
        m_nbits++;
      end
      m_k++;
      m_done = 0;
      if (m_k == TOT) begin
        m_active = 0;
        m_done = 1;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_active = 1; m_k = 0; m_under = 0; m_nbits = 0;
      end
    end
  endtask

  task automatic tick();
    logic [7:0] got, want;
    @(posedge clk);
    model_step();
    #1;
    got = {d_bit_ready, d_carrier_en, d_phase_rst, d_phase_inv,
           d_sym_strobe, d_busy, d_frame_done, d_underrun};
    want = model_out();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cycle_outputs t=%0t k=%0d got=%b want=%b", $time, m_k, got, want);
    end
    if (d_busy) busy_cnt++;
    if (d_phase_rst) pr_cnt++;
    if (d_frame_done) fd_cnt++;
    if (m_active && (m_k % CPS) == CPS / 2) got_pat[m_k / CPS] = d_phase_inv;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One burst on the default instance. drop_at: data bit index whose valid is withheld;
  // restart_at / rst_at: loop index of a stray start or a reset (0 = none); rnd: random source.
  task automatic run_burst(input logic [31:0] word, input int drop_at, input int restart_at,
                           input int rst_at, input bit rnd, input bit under_want);
    logic [NSYM-1:0] want_pat;
    busy_cnt = 0; pr_cnt = 0; fd_cnt = 0; got_pat = '0;
    start = 1'b1;
    bit_valid = 1'b1;
    bit_data = 1'b0;
    tick();
    start = 1'b0;
    for (int n = 1; n < TOT + 3; n++) begin
      rst = (n == rst_at);
      start = (n == restart_at) || (rnd && n < TOT && $urandom_range(0, 199) == 0);
      if (rnd) begin
        bit_valid = ($urandom_range(0, 9) != 0);
        bit_data = $urandom_range(0, 1) == 1;
      end else begin
        bit_valid = (m_nbits != drop_at);
        bit_data = (m_nbits < 32) ? word[31 - m_nbits] : 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    $display("burst word=%h busy=%0d phase_rst=%0d frame_done=%0d underrun=%0b",
             word, busy_cnt, pr_cnt, fd_cnt, d_underrun);
    if (rst_at == 0) begin
      check("busy_len", busy_cnt, TOT);
      check("phase_rst_pulses", pr_cnt, 1);
      check("frame_done_pulses", fd_cnt, 1);
      if (!rnd) begin
        check("underrun_flag", int'(d_underrun), int'(under_want));
        for (int s = 0; s < NSYM; s++) begin
          if (s < PL) want_pat[s] = (s % 2) == 1;
          else if (s < PL + FL) want_pat[s] = (s - PL == drop_at) ? 1'b0 : word[31 - (s - PL)];
          else want_pat[s] = 1'b0;
        end
        total++;
        if (got_pat !== want_pat) begin
          bad++;
          $display("FAIL phase_pattern got=%h want=%h", got_pat, want_pat);
        end
      end
    end
  endtask

  typedef struct {
    logic       start;
    logic       bit_valid;
    logic       bit_data;
    logic [7:0] want;
  } vec_t;

  vec_t vecs [17];

  initial begin
    // Minimal geometry: 2 cycles/symbol, one preamble, one data, no guard.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'b01101100};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'b11000100};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'b01011100};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'b01010100};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'b00000010};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'b01101100};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'b11000100};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'b01001101};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'b01000101};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'b00000011};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'b00000001};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'b01101100};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'b11000100};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'b01001100};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'b01000100};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'b00000010};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'b00000000};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("idle_small_outputs", int'({c_bit_ready, c_carrier_en, c_phase_rst, c_phase_inv,
                                      c_sym_strobe, c_busy, c_frame_done, c_underrun}), 0);

    for (int i = 0; i < 17; i++) begin
      logic [7:0] got;
      c_start = vecs[i].start;
      c_bit_valid = vecs[i].bit_valid;
      c_bit_data = vecs[i].bit_data;
      tick();
      got = {c_bit_ready, c_carrier_en, c_phase_rst, c_phase_inv,
             c_sym_strobe, c_busy, c_frame_done, c_underrun};
      $display("small vec %0d start=%b valid=%b data=%b out=%b", i,
               vecs[i].start, vecs[i].bit_valid, vecs[i].bit_data, got);
      total++;
      if (got !== vecs[i].want) begin
        bad++;
        $display("FAIL small_vec%0d got=%b want=%b", i, got, vecs[i].want);
      end
    end
    c_start = 1'b0;

    run_burst(32'hA5A5A5A5, -1, 0, 0, 1'b0, 1'b0);
    run_burst(32'hFFFFFFFF, 4, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    check("underrun_sticky", int'(d_underrun), 1);
    run_burst(32'h3C96F00D, -1, 500, 0, 1'b0, 1'b0);
    run_burst(32'h12345678, -1, 0, 1000, 1'b0, 1'b0);
    run_burst(32'h0F0F55AA, -1, 0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'($urandom_range(0, 15)); i++) tick();
      run_burst(32'h0, -1, 0, 0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpsk_symbol_scheduler.md
# bpsk_symbol_scheduler

- Sequences the carrier generator for one BPSK burst:
  - preamble;
  - data symbols pulled from an upstream bit source;
  - guard interval with the carrier off.
- Emits the control that drives the carrier datapath: phase reset, enable, and 180° phase-invert per symbol.
- Sits between the bit source/framer and the carrier generator, on the carrier's clock domain.

## Interface
- `CYC_PER_SYM`, default 64: clock cycles per symbol. Must be ≥ 2.
- `PREAMBLE_LEN`, default 8: preamble symbols, alternating 0,1,0,1… Must be ≥ 1.
- `FRAME_LEN`, default 32: data symbols per burst. Must be ≥ 1.
- `GUARD_LEN`, default 2: carrier-off symbols after data. Must be ≥ 0.
- `clk_sig` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: burst request. Sampled only in IDLE.
- `bit_data` input 1: upstream data bit.
- `bit_valid` input 1: `bit_data` is valid.
- `bit_ready` output 1: one-cycle request for the next data bit.
- `carrier_en` output 1: carrier generator output enable.
- `phase_rst` output 1: one-cycle pulse that clears the carrier phase accumulator.
- `phase_inv` output 1: 1 selects 180° carrier phase.
- `sym_strobe` output 1: first cycle of each preamble or data symbol.
- `busy` output 1: burst in progress.
- `frame_done` output 1: one-cycle pulse at burst end.
- `underrun` output 1: sticky flag, a data bit was missing. Cleared on the next accepted `start`.

## Operation
- States: IDLE → PREAMBLE → DATA → GUARD → IDLE. If GUARD_LEN = 0, DATA goes straight to IDLE.
- Counters:
  - `cyc` runs 0..CYC_PER_SYM−1 inside every symbol.
  - `sym` counts symbols within the current state.
  - Widths are `$clog2` of each range, minimum 1.
- IDLE:
  - `start`=1 moves to PREAMBLE with `cyc`=`sym`=0.
  - `underrun` clears.
  - `start` in any other state is ignored.
- PREAMBLE:
  - `phase_inv` = `sym[0]`.
  - Leaves after PREAMBLE_LEN symbols.
- DATA:
  - `phase_inv` = the bit captured for that symbol; bit 1 gives `phase_inv`=1.
  - Leaves after FRAME_LEN symbols.
- GUARD:
  - `carrier_en`=0 and `phase_inv`=0 for GUARD_LEN·CYC_PER_SYM cycles.
- Bit handshake:
  - `bit_ready`=1 for exactly the cycle where `cyc`=CYC_PER_SYM−1 and the next symbol is a data symbol. That covers the last preamble symbol and data symbols 0..FRAME_LEN−2.
  - In that cycle, `bit_valid`=1 captures `bit_data`.
  - `bit_valid`=0 in that cycle forces the bit to 0 and sets `underrun`.
  - The scheduler never stalls; symbol timing is fixed.
- `carrier_en`=1 throughout PREAMBLE and DATA.
- All outputs are registered.

## Timing
- Reset values, all outputs: `bit_ready`, `carrier_en`, `phase_rst`, `phase_inv`, `sym_strobe`, `busy`, `frame_done` and `underrun` are all 0. State is IDLE, counters are 0.
- `start` sampled high at edge T. In cycle T+1:
  - `phase_rst`=1 for that cycle only;
  - `carrier_en`=1, `busy`=1, `sym_strobe`=1;
  - `phase_inv`=0.
- A captured bit appears on `phase_inv` in the cycle right after the `bit_ready` cycle, aligned with `sym_strobe`.
- `busy` is high for exactly (PREAMBLE_LEN+FRAME_LEN+GUARD_LEN)·CYC_PER_SYM cycles. With defaults that is 2688.
- `frame_done`=1 on the first cycle after `busy` falls; state is IDLE in that cycle.
- A new `start` is accepted in the `frame_done` cycle or any later IDLE cycle.
- `rst` mid-burst: at the next edge all outputs and counters return to reset values and any captured bit is dropped. `rst` wins over a simultaneous `start`.
- A `bit_valid` pulse outside the `bit_ready` cycle is ignored.

## Structure
- Shared package `bpsk_pkg` holds:
  - state typedef `sched_state_t` with values IDLE, PREAMBLE, DATA, GUARD;
  - default constants for CYC_PER_SYM, PREAMBLE_LEN, FRAME_LEN and GUARD_LEN, also used by the carrier generator and the framer.
- One sub-module, `symbol_timer`:
  - owns `cyc`;
  - outputs `sym_first` and `sym_last`;
  - is cleared when `start` is accepted.
- The FSM, the `sym` counter and the output registers live in the top module.

## Test plan
- Reset and idle: hold `rst` 2 cycles, release, no `start` for 100 cycles → every output stays 0.
- Defaults, `bit_valid` tied to 1, data 0xA5A5A5A5 sent MSB first:
  - `phase_inv` shows pattern 0101_0101, then the data bits, each held 64 cycles;
  - `busy` lasts 2688 cycles;
  - `frame_done` pulses once;
  - `underrun`=0.
- Underrun: drop `bit_valid` at the 5th `bit_ready` → data symbol 4 has `phase_inv`=0 and `underrun` rises and stays 1 until the next `start`.
- Start ignored while busy: pulse `start` at cycle 500 of a burst → total burst length stays 2688 and `phase_rst` pulses only once.
- Reset mid-DATA: assert `rst` at cycle 1000 → next cycle all outputs 0; a following `start` gives a full burst from preamble symbol 0.
- Parameter corner, CYC_PER_SYM=2, PREAMBLE_LEN=1, FRAME_LEN=1, GUARD_LEN=0:
  - `bit_ready` at cycle T+2, where T+1 is the first burst cycle (`phase_rst`=1);
  - `busy` lasts 4 cycles;
  - `frame_done` in cycle T+5.
